// File: rtl/param_divider.sv
// param_divider: multi-cycle restoring signed/unsigned divider with divide-by-zero detect, cancel and output handshake
module param_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             div_clk,
  input  logic             div_resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_cancel,
  output logic             div_out_valid,
  input  logic             div_out_ready,
  output logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic sgn, neg_a, neg_b;
  logic [WIDTH-1:0] dvd, quo;
  logic [WIDTH:0] b_mag, rem;
  logic [CNT_W-1:0] cnt;
  logic accept, a_neg_in, b_neg_in;
  logic [WIDTH:0] b_ext;
  logic [WIDTH+1:0] trial;
  assign div_ready = state == IDLE;
  assign accept = div_valid & div_ready & ~div_cancel;
  assign a_neg_in = div_signed & dividend[WIDTH-1];
  assign b_neg_in = div_signed & divisor[WIDTH-1];
  assign b_ext = {b_neg_in, divisor};
  // rem never exceeds the divisor magnitude, so the top bit of trial is a clean sign
  assign trial = {rem, dvd[WIDTH-1]} - {1'b0, b_mag};
  always_ff @(posedge div_clk) begin
    if (!div_resetn) begin
      state         <= IDLE;
      div_out_valid <= 1'b0;
      div_quo       <= '0;
      div_rem       <= '0;
      div_by_zero   <= 1'b0;
      cnt           <= '0;
    end else if (state != IDLE && div_cancel) begin
      state         <= IDLE;
      div_out_valid <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn   <= div_signed;
          neg_a <= a_neg_in;
          neg_b <= b_neg_in;
          dvd   <= a_neg_in ? -dividend : dividend;
          b_mag <= b_neg_in ? -b_ext : b_ext;
          cnt   <= '0;
          rem   <= '0;
          quo   <= '0;
          if (divisor == '0) begin
            state         <= DONE;
            div_quo       <= '1;
            div_rem       <= dividend;
            div_by_zero   <= 1'b1;
            div_out_valid <= 1'b1;
          end else state <= CALC;
        end
        CALC: begin
          rem <= trial[WIDTH+1] ? {rem[WIDTH-1:0], dvd[WIDTH-1]} : trial[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          div_quo       <= (sgn & (neg_a ^ neg_b)) ? -quo : quo;
          div_rem       <= neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          div_by_zero   <= 1'b0;
          div_out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: if (div_out_valid & div_out_ready) begin
          div_out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_divider.sv
// tb_param_divider: directed vector table plus hand-written cancel/backpressure/reset sequences on 32- and 8-bit dividers
module tb_param_divider;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  logic v32, s32, c32, or32, r32, ov32, z32;
  logic [31:0] a32, b32, q32, m32;
  logic v8, s8, c8, or8, r8, ov8, z8;
  logic [7:0] a8, b8, q8, m8;
  logic sel;
  logic rdy, ov, dz;
  logic [31:0] quo, rem;
  assign rdy = sel ? r8 : r32;
  assign ov  = sel ? ov8 : ov32;
  assign dz  = sel ? z8 : z32;
  assign quo = sel ? {24'b0, q8} : q32;
  assign rem = sel ? {24'b0, m8} : m32;

  param_divider #(.WIDTH(32)) u32 (
    .div_clk(clk), .div_resetn(resetn), .div_valid(v32), .div_ready(r32),
    .div_signed(s32), .dividend(a32), .divisor(b32), .div_cancel(c32),
    .div_out_valid(ov32), .div_out_ready(or32), .div_quo(q32), .div_rem(m32),
    .div_by_zero(z32));
  param_divider #(.WIDTH(8)) u8 (
    .div_clk(clk), .div_resetn(resetn), .div_valid(v8), .div_ready(r8),
    .div_signed(s8), .dividend(a8), .divisor(b8), .div_cancel(c8),
    .div_out_valid(ov8), .div_out_ready(or8), .div_quo(q8), .div_rem(m8),
    .div_by_zero(z8));

  typedef struct {
    logic        w8;
    logic        sg;
    logic [31:0] a, b, eq, er;
    logic        ez;
  } vec_t;
  vec_t vt[14];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!ov && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    sel = v.w8;
    #0;
    chk("pre_ready", rdy, 1);
    if (v.w8) begin
      v8 = 1; s8 = v.sg; a8 = v.a[7:0]; b8 = v.b[7:0];
    end else begin
      v32 = 1; s32 = v.sg; a32 = v.a; b32 = v.b;
    end
    @(posedge clk); #1;
    v8 = 0; v32 = 0;
    a8 = 8'h5A; b8 = 8'h00; s8 = ~s8;
    a32 = $urandom; b32 = 32'h0; s32 = ~s32;
    wait_ov(n);
    chk("latency", n, v.ez ? 0 : (v.w8 ? 9 : 33));
    chk("quo", quo, v.eq);
    chk("rem", rem, v.er);
    chk("by_zero", dz, v.ez);
    chk("busy_ready", rdy, 0);
    @(posedge clk); #1;
    chk("ovalid_clr", ov, 0);
    chk("ready_back", rdy, 1);
  endtask

  initial begin
    int n, seen;
    resetn = 0; sel = 0;
    v32 = 0; s32 = 0; c32 = 0; or32 = 1; a32 = 0; b32 = 0;
    v8 = 0; s8 = 0; c8 = 0; or8 = 1; a8 = 0; b8 = 0;
    vt[0]  = '{1'b0, 1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    vt[5]  = '{1'b0, 1'b1, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    vt[6]  = '{1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'hFFFFFFF7, 32'hFFFFFFFD,   32'd3,          32'd0,          1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vt[9]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vt[10] = '{1'b1, 1'b0, 32'd255,      32'd16,         32'd15,         32'd15,         1'b0};
    vt[11] = '{1'b1, 1'b1, 32'h80,       32'h03,         32'hD6,         32'hFE,         1'b0};
    vt[12] = '{1'b1, 1'b1, 32'h80,       32'hFF,         32'h80,         32'h00,         1'b0};
    vt[13] = '{1'b0, 1'b0, 32'd9,        32'd3,          32'd3,          32'd0,          1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready32", r32, 1);
    chk("rst_ov32", ov32, 0);
    chk("rst_quo32", q32, 0);
    chk("rst_rem32", m32, 0);
    chk("rst_dz32", z32, 0);
    chk("rst_ready8", r8, 1);
    chk("rst_ov8", ov8, 0);
    resetn = 1;
    for (int i = 0; i < 13; i++) run(vt[i]);
    sel = 0;
    or32 = 0; v32 = 1; s32 = 0; a32 = 100; b32 = 7;
    @(posedge clk); #1;
    v32 = 0;
    wait_ov(n);
    chk("bp_latency", n, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_quo", q32, 14);
      chk("bp_rem", m32, 2);
      chk("bp_ov", ov32, 1);
      chk("bp_ready", r32, 0);
    end
    or32 = 1;
    @(posedge clk); #1;
    chk("bp_ov_clr", ov32, 0);
    chk("bp_ready_back", r32, 1);
    v32 = 1; s32 = 0; a32 = 100; b32 = 7;
    @(posedge clk); #1;
    v32 = 0;
    repeat (4) @(posedge clk);
    #1;
    c32 = 1;
    @(posedge clk); #1;
    c32 = 0;
    chk("calc_cancel_ready", r32, 1);
    chk("calc_cancel_ov", ov32, 0);
    run(vt[13]);
    v32 = 1; c32 = 1; a32 = 100; b32 = 7;
    @(posedge clk); #1;
    v32 = 0; c32 = 0;
    chk("idle_cancel_ready", r32, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32 || !r32) seen = 1;
    end
    chk("idle_cancel_noaccept", seen, 0);
    or32 = 0; v32 = 1; s32 = 0; a32 = 32'h12345678; b32 = 0;
    @(posedge clk); #1;
    v32 = 0;
    chk("done_dz_ov", ov32, 1);
    chk("done_dz_flag", z32, 1);
    c32 = 1;
    @(posedge clk); #1;
    c32 = 0; or32 = 1;
    chk("done_cancel_ov", ov32, 0);
    chk("done_cancel_dz", z32, 0);
    chk("done_cancel_ready", r32, 1);
    sel = 1;
    v8 = 1; s8 = 0; a8 = 8'd255; b8 = 8'd16;
    @(posedge clk); #1;
    v8 = 0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    chk("midrst_quo", q8, 0);
    chk("midrst_rem", m8, 0);
    chk("midrst_ov", ov8, 0);
    chk("midrst_dz", z8, 0);
    chk("midrst_ready", r8, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_divider.md
Name: param_divider

Overview:
- Parametrised multi-cycle restoring integer divider, successor to the fixed 32-bit divider in the execute stage.
- Handles signed and unsigned division at any width and detects divide-by-zero.
- Adds an output valid/ready handshake so a stalled writeback holds the result, and a cancel input that flushes the operation on exception or branch flush.
- Sits beside the multiplier in the EX stage. The pipeline stalls on div_ready/div_out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (legal 4..64).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- div_clk  in  1  clock, all state updates on rising edge
- div_resetn  in  1  synchronous active-low reset
- div_valid  in  1  operation request
- div_ready  out  1  divider can accept; high only in IDLE
- div_signed  in  1  1 = two's-complement operands, 0 = unsigned
- dividend  in  WIDTH  numerator, sampled on accept
- divisor  in  WIDTH  denominator, sampled on accept
- div_cancel  in  1  abort current operation / suppress accept
- div_out_valid  out  1  result available
- div_out_ready  in  1  consumer takes the result
- div_quo  out  WIDTH  quotient
- div_rem  out  WIDTH  remainder
- div_by_zero  out  1  result is from a zero divisor; qualified by div_out_valid

Behaviour:

Reset (div_resetn=0 at an edge)
- state goes to IDLE; div_out_valid=0; div_quo=0; div_rem=0; div_by_zero=0; counter=0.
- Reset mid-operation discards all work with no output.

Accept
- accept = div_valid & div_ready & ~div_cancel.
- div_ready is combinational: state==IDLE.
- On accept, latch div_signed and the operand signs.
- Latch |dividend| and |divisor| as WIDTH+1-bit magnitudes. Signed: sign-extend then negate if negative. Unsigned: zero-extend.

States
- IDLE: on accept, go to CALC, or to DONE if divisor==0. Clear counter and partial remainder; clear the quotient register.
- CALC: one restoring step per cycle.
  - trial = {rem[WIDTH-1:0], next dividend MSB} - |divisor| (WIDTH+2-bit subtract).
  - Non-negative: keep trial and shift in quotient bit 1. Negative: keep the shifted value and shift in 0.
  - After exactly WIDTH steps (counter==WIDTH-1), go to FIX.
- FIX: one cycle.
  - Quotient is negated iff signed and the operand signs differ.
  - Remainder is negated iff signed and the dividend is negative.
  - Register div_quo/div_rem, set div_out_valid=1, go to DONE.
- DONE: hold div_quo, div_rem, div_by_zero and div_out_valid stable while div_out_ready=0.
  - On div_out_valid & div_out_ready, clear div_out_valid and go to IDLE.
  - The next accept is possible no earlier than the following cycle.

Latency
- Accept at edge T gives div_out_valid high after edge T+WIDTH+1 (WIDTH CALC cycles + 1 FIX cycle).
- Divide-by-zero gives div_out_valid high after edge T, i.e. 1-cycle latency.

Divide-by-zero
- div_quo = all ones.
- div_rem = dividend unchanged (raw input bits).
- div_by_zero=1. Applies to both signed and unsigned.

Overflow
- Signed MIN / -1 gives div_quo = MIN (10…0) and div_rem = 0, with no flag. This falls out of the WIDTH+1 magnitude arithmetic and truncation to WIDTH bits.

Cancel
- div_cancel=1 in CALC, FIX or DONE: next state IDLE, div_out_valid=0, div_by_zero=0.
- div_cancel has priority over div_out_ready and over FIX completion.
- Cancel in IDLE blocks the accept in that cycle.

Other rules
- div_quo/div_rem change only in FIX, on the divide-by-zero entry to DONE, or on reset.
- dividend/divisor/div_signed may change freely after accept.
- div_valid while not ready is ignored and is not queued.

Test Plan:
1. WIDTH=32, unsigned: 100/7, div_out_ready=1 -> after 33 cycles quo=14, rem=2, div_by_zero=0; div_ready returns the cycle after the handshake.
2. WIDTH=32, signed: -7/2 -> quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). Then 7/-2 -> quo=-3, rem=1. Then 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0.
3. WIDTH=32, divide by zero: dividend 0x12345678, divisor 0 (signed and unsigned) -> div_out_valid one cycle after accept, quo=0xFFFFFFFF, rem=0x12345678, div_by_zero=1.
4. Backpressure: hold div_out_ready=0 for 10 cycles after div_out_valid -> outputs stable and div_ready=0 throughout. Raise div_out_ready -> one handshake, then IDLE.
5. Cancel: assert div_cancel at CALC cycle 5 -> IDLE next cycle, no div_out_valid. An immediate new request 9/3 gives quo=3, rem=0. div_valid+div_cancel together in IDLE -> no accept.
6. WIDTH=8: unsigned 255/16 -> quo=15, rem=15 after 9 cycles. Signed -128/3 -> quo=-42 (0xD6), rem=-2 (0xFE). Pulse div_resetn=0 mid-CALC -> all outputs 0 and div_ready=1 next cycle.
